// File: rtl/pacman_pkg.sv
// Shared types and constants for the ghost behaviour logic.
package pacman_pkg;

  typedef enum logic [1:0] {
    SCATTER = 2'd0,
    CHASE   = 2'd1,
    FRIGHT  = 2'd2
  } ghost_mode_t;

  localparam int unsigned DEF_NUM_GHOSTS = 3;
  localparam int unsigned BONUS_W        = 11;
  localparam logic [BONUS_W-1:0] BONUS_BASE = BONUS_W'(200);

endpackage

// File: rtl/ghost_mode_scheduler_if.sv
// Game-event inputs and ghost-mode outputs of the ghost mode scheduler.
interface ghost_mode_scheduler_if
  import pacman_pkg::*;
#(
  parameter int unsigned NUM_GHOSTS = DEF_NUM_GHOSTS
);
  logic                  frame_tick;
  logic                  run;
  logic                  restart;
  logic                  pellet_eaten;
  logic [NUM_GHOSTS-1:0] ghost_eaten;
  ghost_mode_t           mode;
  logic [NUM_GHOSTS-1:0] frightened;
  logic                  flash;
  logic                  reverse;
  logic [BONUS_W-1:0]    bonus_pts;
  logic                  bonus_valid;
  logic [2:0]            phase;

  modport master (
    output frame_tick, run, restart, pellet_eaten, ghost_eaten,
    input  mode, frightened, flash, reverse, bonus_pts, bonus_valid, phase
  );

  modport slave (
    input  frame_tick, run, restart, pellet_eaten, ghost_eaten,
    output mode, frightened, flash, reverse, bonus_pts, bonus_valid, phase
  );
endinterface

// File: rtl/frame_timer.sv
// Loadable down-counter stepped by frame ticks; holds at zero.
module frame_timer #(
  parameter int unsigned W = 11
) (
  input  logic         Clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  always_ff @(posedge Clk) begin
    if (load) begin
      count <= load_val;
    end else if (en && tick && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Ghost mode sequencer: scatter/chase schedule, fright override and ghost-eaten bonus arbiter.
module ghost_mode_scheduler
  import pacman_pkg::*;
#(
  parameter int unsigned NUM_GHOSTS     = DEF_NUM_GHOSTS,
  parameter int unsigned TIMER_W        = 11,
  parameter int unsigned SCATTER_FRAMES = 420,
  parameter int unsigned CHASE_FRAMES   = 1200,
  parameter int unsigned FRIGHT_FRAMES  = 360,
  parameter int unsigned FLASH_FRAMES   = 120,
  parameter int unsigned NUM_PHASES     = 4
) (
  input logic Clk,
  input logic Reset,
  ghost_mode_scheduler_if.slave bus
);

  localparam logic [TIMER_W-1:0] SCATTER_LOAD = TIMER_W'(SCATTER_FRAMES - 1);
  localparam logic [TIMER_W-1:0] CHASE_LOAD   = TIMER_W'(CHASE_FRAMES - 1);
  localparam logic [TIMER_W-1:0] FRIGHT_LOAD  = TIMER_W'(FRIGHT_FRAMES - 1);
  localparam logic [2:0]         LAST_PHASE   = 3'(NUM_PHASES - 1);
  localparam logic               FLASH_ON_LOAD = (FRIGHT_FRAMES <= FLASH_FRAMES);

  ghost_mode_t           mode, ret_mode;
  logic [2:0]            phase;
  logic [NUM_GHOSTS-1:0] frightened, pending;
  logic [NUM_GHOSTS-1:0] eaten, req, grant, fr_n, pend_n;
  logic [1:0]            chain;
  logic                  flash, reverse, bonus_valid;
  logic [BONUS_W-1:0]    bonus_pts;

  logic rst, pel, tick_ok, final_chase, base_end, fr_exit;
  logic base_load, base_en, base_zero, fr_load, fr_en, fr_zero;
  logic [TIMER_W-1:0] base_load_val, fr_count, base_count_unused;

  assign rst         = Reset | bus.restart;
  assign pel         = bus.run & bus.pellet_eaten;
  assign tick_ok     = bus.run & bus.frame_tick & ~pel;
  assign final_chase = (mode == CHASE) && (phase == LAST_PHASE);
  assign base_end    = tick_ok && (mode != FRIGHT) && base_zero && !final_chase;

  assign base_load     = rst | base_end;
  assign base_load_val = (!rst && mode == SCATTER) ? CHASE_LOAD : SCATTER_LOAD;
  assign base_en       = bus.run & ~pel & (mode != FRIGHT);
  assign fr_load       = rst | pel;
  assign fr_en         = bus.run & ~pel & (mode == FRIGHT);

  frame_timer #(.W(TIMER_W)) u_base_timer (
    .Clk      (Clk),
    .load     (base_load),
    .load_val (base_load_val),
    .tick     (bus.frame_tick),
    .en       (base_en),
    .count    (base_count_unused),
    .zero     (base_zero)
  );

  frame_timer #(.W(TIMER_W)) u_fright_timer (
    .Clk      (Clk),
    .load     (fr_load),
    .load_val (FRIGHT_LOAD),
    .tick     (bus.frame_tick),
    .en       (fr_en),
    .count    (fr_count),
    .zero     (fr_zero)
  );

  // Newly eaten ghosts join the request set in the same cycle so a bonus follows one edge later.
  always_comb begin
    eaten = '0;
    if (bus.run && !pel) eaten = bus.ghost_eaten & frightened;
    req   = pel ? '0 : (pending | eaten);
    grant = '0;
    for (int unsigned i = NUM_GHOSTS; i > 0; i--) begin
      if (req[i-1]) begin
        grant      = '0;
        grant[i-1] = 1'b1;
      end
    end
    pend_n  = req & ~grant;
    fr_n    = pel ? '1 : (frightened & ~grant);
    fr_exit = (mode == FRIGHT) && !pel &&
              ((tick_ok && fr_zero) || (fr_n == '0 && pend_n == '0));
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      mode        <= SCATTER;
      ret_mode    <= SCATTER;
      phase       <= '0;
      frightened  <= '0;
      pending     <= '0;
      chain       <= '0;
      flash       <= 1'b0;
      reverse     <= 1'b0;
      bonus_pts   <= '0;
      bonus_valid <= 1'b0;
    end else begin
      reverse     <= 1'b0;
      pending     <= pend_n;
      frightened  <= fr_n;
      bonus_valid <= (grant != '0);
      if (grant != '0) begin
        bonus_pts <= BONUS_BASE << chain;
        if (chain != 2'd3) chain <= chain + 2'd1;
      end
      if (pel) begin
        if (mode != FRIGHT) begin
          ret_mode <= mode;
          reverse  <= 1'b1;
        end
        mode  <= FRIGHT;
        chain <= '0;
        flash <= FLASH_ON_LOAD;
      end else if (mode == FRIGHT) begin
        if (fr_exit) begin
          mode       <= ret_mode;
          frightened <= '0;
          flash      <= 1'b0;
          chain      <= '0;
        end else if (tick_ok && !fr_zero) begin
          // Remaining ticks after this decrement equal the current count.
          flash <= (32'(fr_count) <= FLASH_FRAMES);
        end
      end else if (base_end) begin
        reverse <= 1'b1;
        if (mode == SCATTER) begin
          mode <= CHASE;
        end else begin
          mode  <= SCATTER;
          phase <= phase + 3'd1;
        end
      end
    end
  end

  assign bus.mode        = mode;
  assign bus.frightened  = frightened;
  assign bus.flash       = flash;
  assign bus.reverse     = reverse;
  assign bus.bonus_pts   = bonus_pts;
  assign bus.bonus_valid = bonus_valid;
  assign bus.phase       = phase;

endmodule
